// File: rtl/keypad_scanner_gen.sv
// rtl/keypad_scanner_gen.sv - row-scanned keypad with per-key debounce and an event FIFO
// Define KEYPAD_REPEAT_EN to add auto-repeat events (REPEAT_DELAY / REPEAT_RATE, in row scans).
module keypad_scanner_gen #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 500,
  parameter int DEBOUNCE     = 4,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
`endif
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [7:0]      evt_data,
  output logic            evt_ovf,
  input  logic            ovf_clr
);

  localparam int NK        = ROWS * COLS;
  localparam int KW        = $clog2(NK);
  localparam int RW        = $clog2(ROWS);
  localparam int CW        = $clog2(COLS);
  localparam int DWELL_CYC = SCAN_DIV - COLS - 2;
  localparam int DW        = $clog2(DWELL_CYC + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {DWELL, SAMPLE, PROC, NEXT} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   dwell_cnt;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;
  logic [COLS-1:0] samp;
  logic            dwell_run, do_sample, do_proc, do_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DWELL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DWELL:   if (dwell_cnt == DW'(DWELL_CYC - 1)) state_nx = SAMPLE;
      SAMPLE:  state_nx = PROC;
      PROC:    if (col_idx == CW'(COLS - 1)) state_nx = NEXT;
      NEXT:    state_nx = DWELL;
      default: state_nx = DWELL;
    endcase
  end

  always_comb begin
    dwell_run = 1'b0;
    do_sample = 1'b0;
    do_proc   = 1'b0;
    do_next   = 1'b0;
    case (state)
      DWELL:   dwell_run = 1'b1;
      SAMPLE:  do_sample = 1'b1;
      PROC:    do_proc   = 1'b1;
      NEXT:    do_next   = 1'b1;
      default: dwell_run = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      samp      <= '0;
    end else begin
      if (dwell_run && state_nx == DWELL) dwell_cnt <= dwell_cnt + 1'b1;
      else                                dwell_cnt <= '0;
      if (do_sample) samp <= ~col_n;
      if (do_proc)   col_idx <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;
      if (do_next)   row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    end
  end

  assign row_n = ~(ROWS'(1) << row_idx);

  // Only the key addressed by (row_idx, col_idx) is touched in a given PROC cycle.
  logic [NK-1:0] stable;
  logic [3:0]    db_cnt [NK];
  logic [KW-1:0] key_idx;
  logic [3:0]    db_inc;
  logic [5:0]    code;
  logic          samp_bit, stable_k, differs, flip, rpt_fire, push_req;
  logic [7:0]    push_data;

  always_comb begin
    key_idx   = KW'(row_idx) * KW'(COLS) + KW'(col_idx);
    samp_bit  = samp[col_idx];
    stable_k  = stable[key_idx];
    db_inc    = db_cnt[key_idx] + 4'd1;
    differs   = samp_bit ^ stable_k;
    flip      = do_proc && differs && (db_inc == 4'(DEBOUNCE));
    code      = 6'(key_idx);
    push_req  = flip || rpt_fire;
    push_data = {flip & stable_k, rpt_fire, code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NK; i++) db_cnt[i] <= '0;
    end else if (do_proc) begin
      if (!differs) begin
        db_cnt[key_idx] <= '0;
      end else if (flip) begin
        stable[key_idx] <= ~stable_k;
        db_cnt[key_idx] <= '0;
      end else begin
        db_cnt[key_idx] <= db_inc;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // rpt_armed selects between the initial delay and the steady repeat interval.
  logic [7:0] rpt_cnt   [NK];
  logic       rpt_armed [NK];
  logic [7:0] rpt_inc, rpt_lim;

  always_comb begin
    rpt_inc  = rpt_cnt[key_idx] + 8'd1;
    rpt_lim  = rpt_armed[key_idx] ? 8'(REPEAT_RATE) : 8'(REPEAT_DELAY);
    rpt_fire = do_proc && stable_k && samp_bit && (rpt_inc >= rpt_lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NK; i++) begin
        rpt_cnt[i]   <= '0;
        rpt_armed[i] <= 1'b0;
      end
    end else if (do_proc) begin
      if (flip) begin
        rpt_cnt[key_idx]   <= '0;
        rpt_armed[key_idx] <= 1'b0;
      end else if (stable_k && samp_bit) begin
        if (rpt_fire) begin
          rpt_cnt[key_idx]   <= '0;
          rpt_armed[key_idx] <= 1'b1;
        end else begin
          rpt_cnt[key_idx] <= rpt_inc;
        end
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // First-word-fall-through FIFO; the extra pointer bit separates full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, push_ok, ovf_set;

  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop     = !empty && evt_ready;
    push_ok = push_req && (!full || pop);
    ovf_set = push_req && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (ovf_set)      evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

  assign evt_valid = !empty;
  assign evt_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_keypad_scanner_gen.sv
// tb/tb_keypad_scanner_gen.sv - scoreboard bench for keypad_scanner_gen (4x4, SCAN_DIV=12, DEBOUNCE=2, FIFO_DEPTH=2)
module tb_keypad_scanner_gen;

  localparam int SCAN = 48;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_data;
  logic       evt_ovf;
  logic       ovf_clr = 1'b0;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int evt_count = 0;
  logic [7:0] sb [$];
  logic [7:0] sb_exp;

  keypad_scanner_gen #(
    .ROWS(4), .COLS(4), .SCAN_DIV(12), .DEBOUNCE(2),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_DELAY(2), .REPEAT_RATE(1),
`endif
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      evt_count++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got evt_data=%02h, none expected", evt_data);
      end else begin
        sb_exp = sb.pop_front();
        if (evt_data !== sb_exp) begin
          failures++;
          $display("FAIL sb_event: got %02h expected %02h", evt_data, sb_exp);
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; keys = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keys = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (row_n !== 4'b1110) begin failures++; $display("FAIL rst_row_n: got %b expected 1110", row_n); end
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_evt_valid: got %b expected 0", evt_valid); end
    if (evt_data !== 8'h00) begin failures++; $display("FAIL rst_evt_data: got %02h expected 00", evt_data); end
    if (evt_ovf !== 1'b0) begin failures++; $display("FAIL rst_evt_ovf: got %b expected 0", evt_ovf); end
    rst_n = 1'b1;
    wait_edges(11);
    checks++;
    if (row_n !== 4'b1110) begin failures++; $display("FAIL row0_dwell: got %b expected 1110", row_n); end
    wait_edges(1);
    checks++;
    if (row_n !== 4'b1101) begin failures++; $display("FAIL row1_step: got %b expected 1101", row_n); end
  endtask

  task automatic test_latency();
    apply_reset();
    keys[3] = 1'b1;
    sb.push_back(8'h03);
    wait_edges(58);
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL lat_before: got %b expected 0", evt_valid); end
    wait_edges(1);
    checks += 2;
    if (evt_valid !== 1'b1) begin failures++; $display("FAIL lat_valid: got %b expected 1", evt_valid); end
    if (evt_data !== 8'h03) begin failures++; $display("FAIL lat_data: got %02h expected 03", evt_data); end
    wait_edges(8);
    checks++;
    if (evt_data !== 8'h03 || evt_valid !== 1'b1) begin
      failures++; $display("FAIL lat_hold: got %b/%02h expected 1/03", evt_valid, evt_data);
    end
    evt_ready = 1'b1;
    keys[3] = 1'b0;
    sb.push_back(8'h83);
    wait_edges(3*SCAN);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL lat_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_press_release();
    apply_reset();
    evt_ready = 1'b1;
    keys[6] = 1'b1;
    sb.push_back(8'h06);
    wait_edges(69);
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL press_early: got %b expected 0", evt_valid); end
    wait_edges(1);
    checks++;
    if (evt_valid !== 1'b1 || evt_data !== 8'h06) begin
      failures++; $display("FAIL press_time: got %b/%02h expected 1/06", evt_valid, evt_data);
    end
    wait_edges(74);
    keys[6] = 1'b0;
    sb.push_back(8'h86);
    wait_edges(69);
    checks++;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL release_early: got %b expected 0", evt_valid); end
    wait_edges(1);
    checks++;
    if (evt_valid !== 1'b1 || evt_data !== 8'h86) begin
      failures++; $display("FAIL release_time: got %b/%02h expected 1/86", evt_valid, evt_data);
    end
    wait_edges(2*SCAN);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL pr_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_glitch();
    int n0;
    apply_reset();
    evt_ready = 1'b1;
    n0 = evt_count;
    for (int g = 0; g < 2; g++) begin
      keys[0] = 1'b1;
      wait_edges(SCAN);
      keys[0] = 1'b0;
      wait_edges(2*SCAN);
    end
    checks += 2;
    if (evt_count !== n0) begin failures++; $display("FAIL glitch_events: got %0d expected %0d", evt_count, n0); end
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_multi_key();
    apply_reset();
    evt_ready = 1'b1;
    keys[8] = 1'b1; keys[11] = 1'b1;
    sb.push_back(8'h08); sb.push_back(8'h0B);
    wait_edges(3*SCAN);
    keys[8] = 1'b0; keys[11] = 1'b0;
    sb.push_back(8'h88); sb.push_back(8'h8B);
    wait_edges(3*SCAN);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL multi_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_overflow();
    apply_reset();
    keys[1] = 1'b1; keys[2] = 1'b1; keys[3] = 1'b1;
    sb.push_back(8'h01); sb.push_back(8'h02);
    wait_edges(58);
    checks++;
    if (evt_ovf !== 1'b0) begin failures++; $display("FAIL ovf_full_only: got %b expected 0", evt_ovf); end
    ovf_clr = 1'b1;
    wait_edges(1);
    ovf_clr = 1'b0;
    checks += 2;
    if (evt_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b expected 1", evt_ovf); end
    if (evt_data !== 8'h01) begin failures++; $display("FAIL ovf_head: got %02h expected 01", evt_data); end
    wait_edges(5);
    ovf_clr = 1'b1;
    wait_edges(1);
    ovf_clr = 1'b0;
    checks += 2;
    if (evt_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", evt_ovf); end
    if (evt_data !== 8'h01) begin failures++; $display("FAIL ovf_head_kept: got %02h expected 01", evt_data); end
    evt_ready = 1'b1;
    wait_edges(31);
    evt_ready = 1'b0;
    keys = '0;
    sb.push_back(8'h81); sb.push_back(8'h82); sb.push_back(8'h83);
    wait_edges(58);
    evt_ready = 1'b1;
    wait_edges(1);
    checks += 2;
    if (evt_ovf !== 1'b0) begin failures++; $display("FAIL full_push_pop_ovf: got %b expected 0", evt_ovf); end
    if (evt_data !== 8'h82) begin failures++; $display("FAIL full_push_pop_head: got %02h expected 82", evt_data); end
    wait_edges(20);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL ovf_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid_proc();
    int n0;
    apply_reset();
    keys[5] = 1'b1;
    wait_edges(69);
    checks += 2;
    if (evt_valid !== 1'b1) begin failures++; $display("FAIL mid_queued: got %b expected 1", evt_valid); end
    if (row_n !== 4'b1101) begin failures++; $display("FAIL mid_row: got %b expected 1101", row_n); end
    rst_n = 1'b0;
    keys = '0;
    #1;
    checks += 2;
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", evt_valid); end
    if (row_n !== 4'b1110) begin failures++; $display("FAIL mid_rst_row: got %b expected 1110", row_n); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    n0 = evt_count;
    wait_edges(4*SCAN);
    checks += 2;
    if (evt_count !== n0) begin failures++; $display("FAIL mid_no_events: got %0d expected %0d", evt_count, n0); end
    if (evt_valid !== 1'b0) begin failures++; $display("FAIL mid_valid_after: got %b expected 0", evt_valid); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    apply_reset();
    evt_ready = 1'b1;
    keys[5] = 1'b1;
    sb.push_back(8'h05); sb.push_back(8'h45); sb.push_back(8'h45); sb.push_back(8'h45);
    wait_edges(6*SCAN);
    keys[5] = 1'b0;
    sb.push_back(8'h85);
    wait_edges(3*SCAN);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL rpt_drain: got %0d left expected 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_press_release();
    test_glitch();
    test_multi_key();
    test_overflow();
    test_reset_mid_proc();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
